lc3b_issue_queue: RTL

- Parametrised circular FIFO between decode and execute.
- Buffers decoded instruction entries (PC, IR, control word) so decode can run ahead while execute stalls on memory.
- Valid/ready handshake on both sides, plus a single-cycle flush for branch/JSR/TRAP redirects.
- Successor to the single pipeline register: adds depth, occupancy count and flush.

---
 rtl/lc3b_issue_queue_pkg.sv | 30 +++
 rtl/lc3b_issue_queue_iq_ptr.sv | 31 +++
 rtl/lc3b_issue_queue.sv | 111 +++++++++++
 3 files changed

// File: rtl/lc3b_issue_queue_pkg.sv
// Shared LC-3b types used by the issue queue and its integrations.
// Provides the decoded-entry struct that travels from decode to execute
// and the default queue depth.
package lc3b_issue_queue_pkg;

  typedef logic [15:0] lc3b_word;

  // Decoded control signals carried alongside each instruction.
  typedef struct packed {
    logic       ld_pc;
    logic       ld_ir;
    logic       ld_reg;
    logic       ld_cc;
    logic [1:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] pcmux_sel;
    logic [1:0] regfilemux_sel;
  } lc3b_control_word;

  // One queued instruction: fetch PC, raw IR and its decoded control word.
  typedef struct packed {
    lc3b_word         pc;
    lc3b_word         ir;
    lc3b_control_word cw;
  } lc3b_iq_entry;

  localparam int LC3B_IQ_DEPTH = 4;

endpackage

// File: rtl/lc3b_issue_queue_iq_ptr.sv
// Modulo-DEPTH pointer for the issue queue. DEPTH is a power of two, so
// the pointer wraps by plain overflow. clr takes priority over inc.
module lc3b_iq_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_r;

  // Pointer register: clear on reset or flush, advance on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (clr) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + PTR_W'(1'b1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/lc3b_issue_queue.sv
// Circular FIFO between LC-3b decode and execute.
// Buffers decoded entries so decode can run ahead of a stalled execute.
// Valid/ready on both sides, single-cycle flush for control redirects.
// Optional macro LC3B_IQ_BYPASS_EN: when empty, an incoming entry is
// presented at the output in the same cycle and, if taken, never stored.
module lc3b_issue_queue
  import lc3b_issue_queue_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = LC3B_IQ_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  rd_ptr_s;
  logic [PTR_W-1:0]  wr_ptr_s;
  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              bypass_take_s;
  logic              out_valid_s;
  logic [DATA_W-1:0] out_data_s;

  // Full/empty come from the registered count only, so in_ready never
  // depends combinationally on out_ready.
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign in_ready = ~full_s;

  // Output view and transfer qualifiers; flush cancels every transfer.
  always_comb begin
    out_valid_s   = ~empty_s;
    out_data_s    = mem_r[rd_ptr_s];
    bypass_take_s = 1'b0;
`ifdef LC3B_IQ_BYPASS_EN
    if (empty_s && !flush) begin
      out_valid_s   = in_valid;
      out_data_s    = in_data;
      bypass_take_s = in_valid & out_ready;
    end else begin
      bypass_take_s = 1'b0;
    end
`endif
    pop_s  = ~empty_s & out_ready & ~flush;
    push_s = in_valid & ~full_s & ~flush & ~bypass_take_s;
  end

  assign out_valid = out_valid_s;
  assign out_data  = out_data_s;
  assign count     = count_r;

  lc3b_iq_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_s),
    .ptr (rd_ptr_s)
  );

  lc3b_iq_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push_s),
    .ptr (wr_ptr_s)
  );

  // Entry storage: cleared only by reset; flush leaves stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_s] <= in_data;
    end else begin
      mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
    end
  end

  // Occupancy: flush empties the queue, otherwise track push/pop balance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
